// File: rtl/pro_ele_mac.sv
// FP32 dot-product processing element: LANES products per beat, running sum, bias, optional ReLU.
// Also holds the combinational fp32_multiplier and IEEE_754_adder it is built from.

module fp32_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        hi, guard, sticky, inc;
    logic [47:0] prod;
    logic [22:0] mant;
    logic [23:0] rnd;
    logic [9:0]  e_sum, e_fin;

    // Round-to-nearest-even; denormal operands and results flush to signed zero.
    always_comb begin
        sign   = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_nan  = (&a[30:23]) & (|a[22:0]);
        b_nan  = (&b[30:23]) & (|b[22:0]);
        a_inf  = (&a[30:23]) & ~(|a[22:0]);
        b_inf  = (&b[30:23]) & ~(|b[22:0]);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        hi     = prod[47];
        mant   = hi ? prod[46:24] : prod[45:23];
        guard  = hi ? prod[23] : prod[22];
        sticky = hi ? (|prod[22:0]) : (|prod[21:0]);
        inc    = guard & (sticky | mant[0]);
        rnd    = {1'b0, mant} + 24'(inc);
        e_sum  = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, hi};
        e_fin  = e_sum + {9'd0, rnd[23]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            result = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero || (e_fin <= 10'd127)) begin
            result = {sign, 31'd0};
        end else if (e_fin >= 10'd382) begin
            result = {sign, 8'hFF, 23'd0};
        end else begin
            result = {sign, 8'(e_fin - 10'd127), rnd[22:0]};
        end
    end
endmodule

module IEEE_754_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, eff_sub, uf, inc;
    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [4:0]  dcl, lz;
    logic [26:0] ma, mb, mbs, m;
    logic [53:0] sh;
    logic [27:0] sum;
    logic [9:0]  e, e_fin;
    logic [23:0] rnd;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Mantissas carry guard/round/sticky; the smaller operand is aligned with a sticky-collecting shift.
    always_comb begin
        a_zero  = (a[30:23] == 8'h00);
        b_zero  = (b[30:23] == 8'h00);
        a_nan   = (&a[30:23]) & (|a[22:0]);
        b_nan   = (&b[30:23]) & (|b[22:0]);
        a_inf   = (&a[30:23]) & ~(|a[22:0]);
        b_inf   = (&b[30:23]) & ~(|b[22:0]);
        swap    = (b[30:0] > a[30:0]);
        big     = swap ? b : a;
        sml     = swap ? a : b;
        d       = big[30:23] - sml[30:23];
        dcl     = (d > 8'd27) ? 5'd27 : d[4:0];
        ma      = {1'b1, big[22:0], 3'b000};
        mb      = {1'b1, sml[22:0], 3'b000};
        sh      = {mb, 27'd0} >> dcl;
        mbs     = {sh[53:28], sh[27] | (|sh[26:0])};
        eff_sub = big[31] ^ sml[31];
        sum     = eff_sub ? ({1'b0, ma} - {1'b0, mbs}) : ({1'b0, ma} + {1'b0, mbs});
        lz      = lzc27(sum[26:0]);
        uf      = 1'b0;
        if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = {2'b00, big[30:23]} + 10'd1;
        end else begin
            m  = sum[26:0] << lz;
            e  = {2'b00, big[30:23]} - {5'd0, lz};
            uf = ({3'b000, lz} >= big[30:23]);
        end
        inc   = m[2] & (m[3] | m[1] | m[0]);
        rnd   = {1'b0, m[25:3]} + 24'(inc);
        e_fin = e + {9'd0, rnd[23]};
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31]))) begin
            result = 32'h7FC0_0000;
        end else if (a_inf) begin
            result = a;
        end else if (b_inf) begin
            result = b;
        end else if (a_zero && b_zero) begin
            result = {a[31] & b[31], 31'd0};
        end else if (a_zero) begin
            result = b_zero ? 32'd0 : b;
        end else if (b_zero) begin
            result = a;
        end else if (!m[26]) begin
            result = 32'd0;
        end else if (uf) begin
            result = {big[31], 31'd0};
        end else if (e_fin >= 10'd255) begin
            result = {big[31], 8'hFF, 23'd0};
        end else begin
            result = {big[31], e_fin[7:0], rnd[22:0]};
        end
    end
endmodule

module pro_ele_mac #(
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      len,
    input  logic [31:0]           bias,
    input  logic                  relu_en,
    input  logic [32*LANES-1:0]   w_in,
    input  logic [32*LANES-1:0]   x_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  nan_inf
);
    localparam int unsigned NODES = 2 * LANES - 1;

    typedef enum logic [1:0] {IDLE, ACC, BIAS, OUT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      accum_q, accum_d, bias_q, bias_d, out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             relu_q, relu_d, out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d, busy_q, busy_d, nan_inf_q, nan_inf_d;
    logic [31:0]      node [NODES];
    logic [31:0]      add_b, add_y, act_y;
    logic             nan_hit;

    // Heap-ordered tree: leaves hold lane products, node j sums children 2j+1 and 2j+2.
    for (genvar i = 0; i < LANES; i++) begin : g_mul
        fp32_multiplier u_mul (.a(w_in[32*i +: 32]), .b(x_in[32*i +: 32]), .result(node[LANES-1+i]));
    end
    for (genvar j = 0; j < LANES - 1; j++) begin : g_tree
        IEEE_754_adder u_add (.a(node[2*j+1]), .b(node[2*j+2]), .result(node[j]));
    end

    // One adder serves both the running sum (ACC) and the bias stage (BIAS).
    assign add_b = (state_q == BIAS) ? bias_q : node[0];
    IEEE_754_adder u_acc (.a(accum_q), .b(add_b), .result(add_y));

    assign act_y   = (relu_q && add_y[31]) ? 32'd0 : add_y;
    assign nan_hit = &accum_q[30:23];

    always_comb begin
        state_d     = state_q;
        accum_d     = accum_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        bias_d      = bias_q;
        relu_d      = relu_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        nan_inf_d   = nan_inf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len;
                    bias_d    = bias;
                    relu_d    = relu_en;
                    accum_d   = 32'd0;
                    cnt_d     = '0;
                    nan_inf_d = 1'b0;
                    state_d   = (len != '0) ? ACC : BIAS;
                end
            end
            ACC: begin
                nan_inf_d = nan_inf_q | nan_hit;
                if (in_valid && in_ready_q) begin
                    accum_d = add_y;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) state_d = BIAS;
                end
            end
            BIAS: begin
                nan_inf_d   = nan_inf_q | nan_hit | (&add_y[30:23]);
                out_data_d  = act_y;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                nan_inf_d = nan_inf_q | nan_hit;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == ACC);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            accum_q     <= 32'd0;
            cnt_q       <= '0;
            len_q       <= '0;
            bias_q      <= 32'd0;
            relu_q      <= 1'b0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            nan_inf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            accum_q     <= accum_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            nan_inf_q   <= nan_inf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign nan_inf   = nan_inf_q;
endmodule

// File: doc/pro_ele_mac.md
Name: pro_ele_mac

Overview:
- Parametrised successor of the single-lane FP32 processing element: one neuron dot product plus bias, optional ReLU.
- Accumulates LANES weight×input products per accepted beat over a programmable beat count.
- Uses valid/ready handshakes on the input stream and the result, so it can be tiled into layer arrays fed by weight/activation buffers.
- Reuses the combinational fp32_multiplier and IEEE_754_adder.

Parameters:
- LANES, 1: products per beat; power of two, 1..8; summed by a balanced adder tree.
- CNT_W, 10: width of the beat-count field.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a new dot product; sampled only in IDLE
- len  in  CNT_W  number of beats to accumulate; sampled with start
- bias  in  32  FP32 bias; sampled with start
- relu_en  in  1  apply ReLU to the result; sampled with start
- w_in  in  32*LANES  FP32 weights, lane i at bits [32i+31:32i]
- x_in  in  32*LANES  FP32 inputs, same packing
- in_valid  in  1  w_in/x_in beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- out_data  out  32  FP32 result
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accepts result
- busy  out  1  high in any state except IDLE
- nan_inf  out  1  sticky: accumulator or result exponent reached 8'hFF during this operation

Behaviour:
- Async reset (reset_n=0): state IDLE; accum, out_data, beat counter = 0; out_valid, in_ready, busy, nan_inf = 0. Reset wins over everything; it aborts an operation at any point and the partial sum is discarded.
- States:
  - IDLE: start=1 latches len/bias/relu_en, clears accum (+0.0), counter and nan_inf. Next state is ACC if len≠0, else BIAS.
  - ACC: in_ready=1. On each handshake, accum <= accum + tree_sum(w_in[i]*x_in[i]) and counter += 1. A cycle with in_valid=0 leaves all state unchanged. The handshake that makes counter==len moves to BIAS.
  - BIAS: in_ready=0. One cycle: out_data <= act(accum+bias); out_valid <= 1; state → OUT.
  - OUT: out_data and out_valid held stable. out_valid&out_ready → out_valid=0, state → IDLE.
- start outside IDLE is ignored, including the OUT cycle where out_ready is accepted. A new start is taken no earlier than the cycle after return to IDLE.
- Latency:
  - Last beat accepted at edge k → out_valid high after edge k+1.
  - len=0: start at edge s → out_valid after edge s+1, out_data=act(bias).
  - Throughput: one beat per clock. Back-to-back operations cost len+3 cycles minimum.
- Arithmetic:
  - IEEE-754 single precision via the existing adder/multiplier. Rounding and denormal handling are as those modules implement.
  - Adder tree is combinational, log2(LANES) levels, lane-order pairing fixed: (0+1),(2+3),...
  - Accumulation is in lane-tree-then-running-sum order, so results are deterministic.
- act(v): if relu_en and v[31]=1 → 32'h00000000 (both −0.0 and negative values); else v. NaN passes unchanged.
- nan_inf: set when the registered accum or the BIAS-stage sum has exponent 8'hFF; cleared only by start or reset.
- len counter width CNT_W; maximum len = 2^CNT_W−1. No wrap: the counter stops at len.

Test Plan:
- LANES=1, len=3, w={3F800000,40000000,40400000}, x all 3F800000, bias=3F000000, relu off → out_data=40D00000 (6.5), out_valid one cycle after the third beat's edge.
- LANES=1, len=1, w=3F800000, x=C0000000, bias=3F000000: relu_en=0 → BFC00000; repeat with relu_en=1 → 00000000.
- len=0, bias=40400000, relu off → no in_ready, out_data=40400000, out_valid after the second edge following start.
- LANES=4, len=1, all w=3F800000, all x=40000000, bias=0 → 41000000. Then len=2 with in_valid gaps of 3 cycles and out_ready held low for 5 cycles → 41800000 stable until accepted; a start pulse during OUT is ignored (busy stays 1).
- Reset mid-ACC after 2 of 4 beats → all outputs 0 asynchronously. A new start, len=1, w=x=3F800000, bias=0 → 3F800000 (no residue).
- w=7F800000 (inf), x=3F800000 → nan_inf=1, sticky through OUT, cleared by the next start.
